// File: rtl/ps2_host_tx_if.sv
// CPU-side transmit handshake for the PS/2 host transmit sequencer.
// The register logic drives the byte and request; the sequencer reports busy/done/error.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_req,
        input  tx_busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_req,
        output tx_busy,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmit sequencer: clock inhibit, request-to-send, bit shifting on
// the device clock, ACK check and timeout. Pin outputs are open-drain style (1 = release).
module ps2_host_tx #(
    parameter int unsigned SYSCLK_FREQUENCY = 1000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned TIMEOUT_MS       = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_out,
    output logic          ps2_dat_out,
    ps2_host_tx_if.slave  bus
);

    localparam int unsigned InhCyc = SYSCLK_FREQUENCY * INHIBIT_US / 10;
    localparam int unsigned ToCyc  = SYSCLK_FREQUENCY * 100 * TIMEOUT_MS;
    localparam int unsigned MaxCyc = (InhCyc > ToCyc) ? InhCyc : ToCyc;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StData,
        StAck,
        StWaitIdle,
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      data_q, data_d;
    logic            par_q, par_d;
    logic [1:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      dat_sync_q, dat_sync_d;
    logic            clk_prev_q, clk_prev_d;

    logic            fe;
    logic            timed;
    logic [3:0]      bit_sel;

    assign clk_sync_d = {clk_sync_q[0], ps2_clk_in};
    assign dat_sync_d = {dat_sync_q[0], ps2_dat_in};
    assign clk_prev_d = clk_sync_q[1];
    assign fe         = clk_prev_q & ~clk_sync_q[1];
    assign timed      = (state_q == StData) || (state_q == StAck) || (state_q == StWaitIdle);
    assign bit_sel    = bit_idx_q - 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_q      <= par_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    // Outputs decode straight from state_q so an async reset releases both lines at once.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        data_d      = data_q;
        par_d       = par_q;
        ps2_clk_out = 1'b1;
        ps2_dat_out = 1'b1;
        bus.tx_busy = (state_q != StIdle);
        bus.tx_done = 1'b0;
        bus.tx_err  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.tx_req) begin
                    data_d  = bus.tx_data;
                    par_d   = ~^bus.tx_data;
                    cnt_d   = CntW'(InhCyc);
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                ps2_clk_out = 1'b0;
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q <= CntW'(1)) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                ps2_clk_out = 1'b0;
                ps2_dat_out = 1'b0;
                bit_idx_d   = '0;
                cnt_d       = CntW'(ToCyc);
                state_d     = StData;
            end
            StData: begin
                // bit_idx_q counts device falling edges seen: 0 = start bit still on the line.
                if (bit_idx_q == 4'd0) begin
                    ps2_dat_out = 1'b0;
                end else if (bit_idx_q <= 4'd8) begin
                    ps2_dat_out = data_q[bit_sel[2:0]];
                end else begin
                    ps2_dat_out = par_q;
                end
                if (fe) begin
                    if (bit_idx_q == 4'd9) begin
                        state_d = StAck;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            StAck: begin
                if (fe) begin
                    state_d = dat_sync_q[1] ? StErr : StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_sync_q[1] && dat_sync_q[1]) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.tx_done = 1'b1;
                state_d     = StIdle;
            end
            StErr: begin
                bus.tx_err = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Timeout overrides any edge-driven transition taken in the same cycle.
        if (timed) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CntW'(1)) begin
                state_d = StErr;
            end
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmit sequencer for one PS/2 port (keyboard or mouse), placed between the CPU-side PS/2 register logic and the open-drain clk/dat pins at toplevel.
- Owns the "out" side of the open-drain pair: clock inhibit, request-to-send, bit shifting on device clock, ACK check, timeout.
- Outputs use release semantics: 1 = high-Z, 0 = drive low. This matches the toplevel tristate mapping.

Parameters:
- SYSCLK_FREQUENCY, 1000: clk frequency in units of 100 kHz (1000 = 100 MHz).
- INHIBIT_US, 100: clock-inhibit time before request-to-send, in µs.
- TIMEOUT_MS, 15: maximum time from clock release to ACK, in ms.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- ps2_clk_in, input, 1: raw PS/2 clock pin level (asynchronous).
- ps2_dat_in, input, 1: raw PS/2 data pin level (asynchronous).
- ps2_clk_out, output, 1: 0 = pull clock low, 1 = release.
- ps2_dat_out, output, 1: 0 = pull data low, 1 = release.
- tx_data, input, 8: byte to send.
- tx_req, input, 1: single-cycle request, sampled only in IDLE.
- tx_busy, output, 1: high from the cycle after acceptance until return to IDLE.
- tx_done, output, 1: one-cycle pulse on successful ACK and bus idle.
- tx_err, output, 1: one-cycle pulse on timeout or missing ACK.

Behaviour:
- Reset (async) values:
  - ps2_clk_out=1, ps2_dat_out=1, tx_busy=0, tx_done=0, tx_err=0; state=IDLE.
  - Asserting reset mid-transfer releases both lines immediately, with no clk edge required.
- Input synchronisation: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchroniser. A falling edge ("fe") is a synced-clock previous=1, current=0, giving a 1-cycle pulse.
- Derived constants:
  - INH_CYC = SYSCLK_FREQUENCY*INHIBIT_US/10.
  - TO_CYC = SYSCLK_FREQUENCY*100*TIMEOUT_MS.
  - Counter width is $clog2 of the larger constant plus 1.
- Parity: odd parity, par = ~^tx_data, latched together with the data byte.
- IDLE:
  - Both lines released.
  - tx_req=1 latches tx_data and par, loads the counter with INH_CYC, and moves to INHIBIT.
  - tx_busy=1 from the next cycle.
  - tx_req in any other state is ignored and causes no queueing.
- INHIBIT:
  - ps2_clk_out=0, ps2_dat_out=1; counter decrements.
  - At counter 0, move to START.
- START (exactly 1 cycle):
  - ps2_clk_out=0, ps2_dat_out=0 (start bit).
  - Next: RTS; bit index=0; timeout counter=TO_CYC.
- RTS/DATA:
  - ps2_clk_out=1; ps2_dat_out holds the current bit.
  - On each fe, advance the data line (data changes only while the device clock is low):
    - fe #1..#8: drive data[0]..data[7], LSB first.
    - fe #9: drive par.
    - fe #10: release (stop bit = 1), then go to ACK.
- ACK:
  - Data line released.
  - On the next fe, sample synced data:
    - 0 → WAIT_IDLE.
    - 1 → ERR.
- WAIT_IDLE: when synced clk=1 and synced dat=1 in the same cycle, go to DONE.
- DONE (1 cycle): tx_done=1; next IDLE with tx_busy=0 in that same next cycle.
- ERR (1 cycle):
  - Both lines released, tx_err=1; next IDLE.
  - ERR and DONE are mutually exclusive.
- Timeout:
  - Counts down in RTS, DATA, ACK and WAIT_IDLE.
  - Reaching 0 in any of these states → ERR, regardless of pending fe.
  - If fe and timeout coincide, timeout wins.
- Line glitches: an fe seen while in INHIBIT or START is ignored (the host is holding clk low).
- Device-initiated traffic while IDLE is not this block's concern; the lines stay released.

Test Plan:
Bench parameters: SYSCLK_FREQUENCY=10 (1 MHz), INHIBIT_US=100, TIMEOUT_MS=2, giving INH_CYC=100 and TO_CYC=2000. The device model clocks at 50 cycles per half-period.
1. Reset held mid-INHIBIT, with ps2_clk_out=0 → ps2_clk_out=1 and ps2_dat_out=1 combinationally. After release: tx_busy=0, and no tx_done or tx_err pulse.
2. tx_req with tx_data=0xED → clk held low exactly 100 cycles, then 1 cycle with both lines low. The device model samples 0,1,0,1,1,0,1,1,1 on rising edges: data LSB first, then parity bit 8 = 1 (the byte has 6 ones, so odd parity = 1). Stop bit = 1. Device ACKs with dat=0 → tx_done pulses once, tx_busy falls, tx_err stays 0.
3. tx_data=0x00 → parity bit = 1. tx_data=0xFF → parity bit = 1. 0x01 → parity bit = 0.
4. Device model never clocks after release → tx_err pulses exactly 2000 cycles after entering RTS (±2 for the synchroniser). Both lines released; back to IDLE.
5. Device omits ACK (dat stays high on fe #11) → tx_err=1 for one cycle, tx_done never asserts.
6. Second tx_req pulses during DATA → ignored: exactly one frame on the wire and one tx_done. A tx_req one cycle after tx_done is accepted.
